// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path.
// Optional STORE_BYTE_MASK_EN selects byte-enable writes instead of RMW.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    function automatic logic store_err(input logic [2:0] f3,
                                       input logic [1:0] off);
        logic e;
        e = 1'b1;
        if (f3 == F3_SB) e = 1'b0;
        if (f3 == F3_SH) e = off[0];
        if (f3 == F3_SW) e = |off;
        return e;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge and byte-enable generation for sub-word stores.
// mask=1 gives replicated data with lane enables; mask=0 merges into rdata.
module store_merge
    import store_pkg::*;
(
    input  logic        mask,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic [3:0]  be
);

    always_comb begin
        data = rdata;
        be   = BE_ALL;
        if (mask) begin
            data = wdata;
            unique case (1'b1)
                (funct3 == F3_SB): begin
                    data = {4{wdata[7:0]}};
                    be   = BE_BYTE << off;
                end
                (funct3 == F3_SH): begin
                    data = {2{wdata[15:0]}};
                    be   = BE_HALF << {off[1], 1'b0};
                end
                default: ;
            endcase
        end else begin
            unique case (1'b1)
                (funct3 == F3_SB): data[8*off +: 8] = wdata[7:0];
                (funct3 == F3_SH): data[16*off[1] +: 16] = wdata[15:0];
                (funct3 == F3_SW): data = wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/store_rmw.sv
// Store unit: word writes direct, sub-word stores via read-modify-write.
// STORE_BYTE_MASK_EN: sub-word stores use byte enables and skip the read.
module store_rmw
    import store_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_funct3,
    input  logic [DW-1:0] req_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          done,
    output logic          err
);

`ifdef STORE_BYTE_MASK_EN
    localparam logic MASK_EN = 1'b1;
`else
    localparam logic MASK_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [DW-1:0] wd_q, wd_d;

    logic          req_d, we_d, done_d, err_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [3:0]    be_d;

    logic          idle;
    logic [2:0]    m_f3;
    logic [1:0]    m_off;
    logic [DW-1:0] m_wd, m_data;
    logic [3:0]    m_be;

    assign idle      = (state_q == IDLE);
    assign req_ready = idle;

    // In IDLE the merge sees the incoming request, later the latched one.
    assign m_f3  = idle ? req_funct3     : f3_q;
    assign m_off = idle ? req_addr[1:0]  : off_q;
    assign m_wd  = idle ? req_wdata      : wd_q;

    store_merge u_merge (
        .mask   (MASK_EN),
        .rdata  (mem_rdata),
        .wdata  (m_wd),
        .off    (m_off),
        .funct3 (m_f3),
        .data   (m_data),
        .be     (m_be)
    );

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        wd_d    = wd_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        be_d    = mem_be;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = req_addr[1:0];
                    wd_d  = req_wdata;
                    if (store_err(req_funct3, req_addr[1:0])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d = {req_addr[AW-1:2], 2'b00};
                        req_d  = 1'b1;
                        if (req_funct3 == F3_SW) begin
                            state_d = WR_REQ;
                            we_d    = 1'b1;
                            wdata_d = req_wdata;
                            be_d    = BE_ALL;
                        end else begin
`ifdef STORE_BYTE_MASK_EN
                            state_d = WR_REQ;
                            we_d    = 1'b1;
                            wdata_d = m_data;
                            be_d    = m_be;
`else
                            state_d = RD_REQ;
                            we_d    = 1'b0;
                            be_d    = BE_ALL;
`endif
                        end
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt) begin
                    state_d = RD_WAIT;
                    req_d   = 1'b0;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    state_d = WR_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = m_data;
                    be_d    = m_be;
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            wd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= BE_NONE;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            wd_q      <= wd_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_be    <= be_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw with a memory responder and a write/done scoreboard.
// Build with STORE_BYTE_MASK_EN to cover the byte-enable variant.
module tb_store_rmw;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        done, err;

    store_rmw #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [67:0] wq[$];
    logic        dq[$];

    int          gnt_delay = 0;
    bit          rv_en = 1'b1;
    logic [31:0] rd_val = '0;
    bit          rd_pend = 1'b0;
    int          cnt = 0;
    bit          req_seen = 1'b0;
    bit          done_seen = 1'b0;

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay cycles, read data one cycle later.
    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        if (rd_pend && rv_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_val;
        end
        rd_pend = 1'b0;
        mem_gnt = 1'b0;
        if (mem_req && !rst) begin
            if (cnt >= gnt_delay) begin
                mem_gnt = 1'b1;
                cnt = 0;
                if (!mem_we) rd_pend = 1'b1;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    logic [68:0] prev = '0;
    bit          prev_wait = 1'b0;

    always @(negedge clk) begin
        if (mem_req) req_seen = 1'b1;
        if (done) done_seen = 1'b1;
        if (!rst) begin
            if (prev_wait && mem_req)
                chk("stable", {mem_we, mem_addr, mem_wdata, mem_be}, prev);
`ifndef STORE_BYTE_MASK_EN
            if (mem_req) chk("be_all", mem_be, 4'hf);
`endif
            if (mem_req && mem_gnt && mem_we) begin
                if (wq.size() == 0)
                    chk("wr_unexpected", mem_gnt, 1'b0);
                else
                    chk("write", {mem_addr, mem_wdata, mem_be}, wq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0)
                    chk("done_unexpected", done, 1'b0);
                else
                    chk("done_err", err, dq.pop_front());
            end
        end
        prev_wait = mem_req && !mem_gnt && !rst;
        prev = {mem_we, mem_addr, mem_wdata, mem_be};
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, input bit now);
        if (!now) @(negedge clk);
        chk("ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f;
        req_wdata  = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata, mem_be}, 69'd0);
        chk("rst_done", {done, err}, 2'b00);
        rst = 1'b0;

        gnt_delay = 0;
        wq.push_back({32'h100, 32'hDEADBEEF, 4'hf});
        dq.push_back(1'b0);
        issue(32'h100, F3_SW, 32'hDEADBEEF, 1'b0);
        wait_done("sw_lat", 2);

        rd_val = 32'h11223344;
`ifdef STORE_BYTE_MASK_EN
        wq.push_back({32'h200, 32'hAAAAAAAA, 4'h8});
        dq.push_back(1'b0);
        issue(32'h203, F3_SB, 32'h000000AA, 1'b0);
        wait_done("sb_lat", 2);
`else
        wq.push_back({32'h200, 32'hAA223344, 4'hf});
        dq.push_back(1'b0);
        issue(32'h203, F3_SB, 32'h000000AA, 1'b0);
        wait_done("sb_lat", 4);
`endif

        // Back-to-back: accept in the done cycle of the previous store.
        gnt_delay = 3;
`ifdef STORE_BYTE_MASK_EN
        wq.push_back({32'h300, 32'hBEEFBEEF, 4'hc});
        dq.push_back(1'b0);
        issue(32'h302, F3_SH, 32'h0000BEEF, 1'b1);
        wait_done("sh_lat", 5);
`else
        wq.push_back({32'h300, 32'hBEEF3344, 4'hf});
        dq.push_back(1'b0);
        issue(32'h302, F3_SH, 32'h0000BEEF, 1'b1);
        wait_done("sh_lat", 10);
`endif
        gnt_delay = 0;

        req_seen = 1'b0;
        dq.push_back(1'b1);
        issue(32'h101, F3_SW, 32'h12345678, 1'b0);
        wait_done("err_sw_lat", 1);
        dq.push_back(1'b1);
        issue(32'h103, F3_SH, 32'h0000ABCD, 1'b0);
        wait_done("err_sh_lat", 1);
        dq.push_back(1'b1);
        issue(32'h104, 3'b011, 32'h0, 1'b0);
        wait_done("err_f3_lat", 1);
        chk("err_no_req", req_seen, 1'b0);

`ifdef STORE_BYTE_MASK_EN
        wq.push_back({32'h200, 32'h5A5A5A5A, 4'h4});
        dq.push_back(1'b0);
        issue(32'h202, F3_SB, 32'h0000005A, 1'b0);
        wait_done("sb_mask_lat", 2);
`else
        wq.push_back({32'h200, 32'h115A3344, 4'hf});
        dq.push_back(1'b0);
        issue(32'h202, F3_SB, 32'h0000005A, 1'b0);
        wait_done("sb2_lat", 4);

        rv_en = 1'b0;
        issue(32'h204, F3_SB, 32'h00000077, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rdwait_req", mem_req, 1'b0);
        chk("rdwait_busy", req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        done_seen = 1'b0;
        @(negedge clk);
        chk("abort_req", mem_req, 1'b0);
        chk("abort_ready", req_ready, 1'b1);
        rv_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_seen, 1'b0);
`endif

        wq.push_back({32'h400, 32'h12345678, 4'hf});
        dq.push_back(1'b0);
        issue(32'h400, F3_SW, 32'h12345678, 1'b0);
        wait_done("sw2_lat", 2);

        repeat (3) @(negedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_rmw.md
# store_rmw

Store-path counterpart of the load extender: takes a store request (address, funct3, register data) from the memory stage and writes it to a word-wide data memory. Word stores go out as a single write. Byte and halfword stores are merged into the addressed lanes with a read-modify-write sequence. Misaligned or unsupported stores are rejected without memory traffic. Sits between the MEM-stage store logic and the data-memory port.

## Interface
Parameters:
- AW, 32, byte-address width
- DW, 32, data width; fixed at 32, four byte lanes

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous and active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_addr  in  AW  byte address
- req_funct3  in  3  000 SB, 001 SH, 010 SW; other codes are errors
- req_wdata  in  DW  register data; low byte or low half used for SB/SH
- mem_req  out  1  memory request; held until granted
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word address: {req_addr[AW-1:2], 2'b00}
- mem_wdata  out  DW  write data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: store rejected

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Accept on req_valid && req_ready. Address, funct3 and data are latched.
- Error check happens at accept:
  - SH with addr[0]=1 is an error.
  - SW with addr[1:0]≠0 is an error.
  - funct3 ∉ {000, 001, 010} is an error.
  - On error, state stays IDLE and done=err=1 in the next cycle. No mem_req is raised.
- SW aligned: IDLE→WR_REQ with mem_we=1, mem_wdata=req_wdata, mem_be=4'b1111.
- SB/SH without the macro:
  - IDLE→RD_REQ with mem_we=0.
  - RD_REQ→RD_WAIT on mem_gnt.
  - RD_WAIT→WR_REQ on mem_rvalid. The merged word is captured at this point.
- Merge rule:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other lanes keep mem_rdata.
- WR_REQ→IDLE on mem_gnt. done=1, err=0 in the following cycle.
- mem_addr is constant for the whole transaction.
- mem_rvalid outside RD_WAIT is ignored.
- mem_rvalid never arrives in the same cycle as the read mem_gnt.

## Timing
- All outputs except req_ready are registered. req_ready is the decode (state==IDLE).
- Reset values:
  - state IDLE, so req_ready=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0.
- Latency from accept (cycle 0), with zero-wait memory:
  - SW: mem_req at cycle 1, done at cycle 2.
  - SB/SH with 1-cycle read: read request at cycle 1, rvalid at cycle 2, write request at cycle 3, done at cycle 4.
  - Error: done/err at cycle 1.
- mem_req, mem_we, mem_addr, mem_wdata and mem_be stay stable while mem_req=1 && !mem_gnt.
- The done cycle coincides with IDLE and req_ready=1. A new request may be accepted in the same cycle, so back-to-back stores are allowed.
- rst mid-transaction aborts it: mem_req=0 on the next cycle, no done is issued, and any partial read result is discarded.

## Configuration
- STORE_BYTE_MASK_EN defined:
  - SB/SH skip the read.
  - IDLE→WR_REQ directly, with mem_wdata holding the data replicated across lanes (SB: {4{b}}, SH: {2{h}}).
  - mem_be = 0001<<addr[1:0] for SB, 0011<<{addr[1],1'b0} for SH.
  - Sub-word latency equals SW latency.
- Macro undefined: RMW path as above; mem_be is always 4'b1111 whenever mem_req=1.

## Structure
- Shared package store_pkg:
  - funct3 constants F3_SB, F3_SH, F3_SW.
  - State encoding.
  - Lane/byte-enable helper constants.
- Sub-module store_merge: combinational lane merge and byte-enable generation (rdata, wdata, addr[1:0], funct3 → merged word, be).
- The FSM, request latch and output registers stay in store_rmw.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt immediate → one write: mem_addr 0x100, be 1111, wdata 0xDEADBEEF; done at cycle 2, err=0.
- SB addr 0x203, data 0x000000AA, mem_rdata 0x11223344 → read, then write of 0xAA223344; done at cycle 4.
- SH addr 0x302, data 0x0000BEEF, mem_rdata 0x11223344, gnt delayed 3 cycles on each request → write 0xBEEF3344; request fields stable while waiting.
- SW addr 0x101, then SH addr 0x103, then funct3 011 → each gives done=err=1 one cycle after accept; mem_req never asserted.
- rst asserted in RD_WAIT of an SB → mem_req=0 next cycle, no done, req_ready=1; the next SW completes normally.
- With STORE_BYTE_MASK_EN: SB addr 0x202, data 0x5A → single write, be 0100, wdata 0x5A5A5A5A; done at cycle 2.
